// File: rtl/avalon_onchip_ram_pkg.sv
// Shared types and helpers for the Avalon-MM on-chip RAM slave.
// Holds the FSM state enum, read latency limits and byte parity.
package avalon_onchip_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    // Even parity bit for one byte: byte plus bit has even weight.
    function automatic logic par8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/avalon_onchip_ram_if.sv
// Avalon-MM slave bus bundle for the on-chip RAM.
// The master modport drives commands, the slave modport answers.
interface avalon_onchip_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) ();
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic                  read;
    logic                  write;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;
    logic                  parity_error;

    modport master (
        output chipselect, address, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest, parity_error
    );

    modport slave (
        input  chipselect, address, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest, parity_error
    );
endinterface

// File: rtl/avalon_onchip_ram_array.sv
// Single-port synchronous RAM with byte enables and registered read.
// With AVALON_ONCHIP_RAM_PARITY_EN defined, one parity bit per byte is kept.
module avalon_onchip_ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 40000,
    parameter int IDX_W  = 16,
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [NB-1:0]     be,
    input  logic [DATA_W-1:0] wdata,
`ifdef AVALON_ONCHIP_RAM_PARITY_EN
    input  logic [NB-1:0]     wpar,
    output logic [NB-1:0]     rpar,
`endif
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-masked write into the data array.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

`ifdef AVALON_ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] pmem [DEPTH];
    logic [NB-1:0] rpar_q;

    // Parity bits follow the same byte enables as the data.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) pmem[idx][i] <= wpar[i];
            end
        end
    end

    // Parity read register tracks the data read register.
    always_ff @(posedge clk) begin
        if (re) rpar_q <= pmem[idx];
    end

    assign rpar = rpar_q;
`endif

endmodule

// File: rtl/avalon_onchip_ram.sv
// Avalon-MM on-chip RAM slave: zero-fill sequencer, pipelined reads.
// Define AVALON_ONCHIP_RAM_PARITY_EN to store and check byte parity.
module avalon_onchip_ram
    import avalon_onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 40000,
    parameter int ADDR_W         = 16,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic               reset_req,
    avalon_onchip_ram_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam state_e RST_STATE =
        (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               rdy_q, rdy_d;
    logic               v1_q, v1_d;
    logic               oor1_q, oor1_d;

    logic               en;
    logic               wreq;
    logic               in_range;
    logic               acc, wr_acc, rd_acc;
    logic               clr_we;

    logic               ram_we, ram_re;
    logic [IDX_W-1:0]   ram_idx;
    logic [NB-1:0]      ram_be;
    logic [DATA_W-1:0]  ram_wdata, ram_rdata;

    logic [DATA_W-1:0]  d1;
    logic               perr1;
    logic               out_v, out_p;
    logic [DATA_W-1:0]  out_d;

    assign en       = clken & ~reset_req;
    assign wreq     = (state_q == ST_CLEAR) | ~rdy_q | ~en;
    assign in_range = {1'b0, bus.address} < DEPTH_X;
    assign acc      = bus.chipselect & ~wreq & (bus.read | bus.write);
    assign wr_acc   = acc & bus.write;
    assign rd_acc   = acc & bus.read & ~bus.write;

    // Control state, clear counter and post-reset ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            v1_q    <= 1'b0;
            oor1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            v1_q    <= v1_d;
            oor1_q  <= oor1_d;
        end
    end

    // Clear sequencer: one zero word per enabled cycle, then RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        rdy_d   = 1'b1;
        unique case (state_q)
            ST_CLEAR: begin
                if (en) begin
                    clr_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // RAM port mux: the sequencer owns the port during CLEAR.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_idx   = bus.address[IDX_W-1:0];
        ram_be    = bus.byteenable;
        ram_wdata = bus.writedata;
        if (state_q == ST_CLEAR) begin
            ram_we    = clr_we;
            ram_idx   = cnt_q;
            ram_be    = '1;
            ram_wdata = '0;
        end else begin
            ram_we = wr_acc & in_range;
            ram_re = rd_acc & in_range;
        end
    end

    // First read stage tracks the RAM register; frozen when disabled.
    always_comb begin
        v1_d   = v1_q;
        oor1_d = oor1_q;
        if (en) begin
            v1_d   = rd_acc;
            oor1_d = ~in_range;
        end
    end

    assign d1 = oor1_q ? '0 : ram_rdata;

`ifdef AVALON_ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] ram_wpar, ram_rpar;

    // Parity of the word being written (zero during clear).
    always_comb begin
        ram_wpar = '0;
        for (int i = 0; i < NB; i++) begin
            ram_wpar[i] = par8(ram_wdata[i*8 +: 8]);
        end
    end

    // Recompute parity on the read word; out-of-range never flags.
    always_comb begin
        perr1 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (par8(ram_rdata[i*8 +: 8]) != ram_rpar[i]) perr1 = 1'b1;
        end
        perr1 = perr1 & ~oor1_q;
    end

    avalon_onchip_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .NB     (NB)
    ) u_array (
        .clk    (clk),
        .we     (ram_we),
        .re     (ram_re),
        .idx    (ram_idx),
        .be     (ram_be),
        .wdata  (ram_wdata),
        .wpar   (ram_wpar),
        .rpar   (ram_rpar),
        .rdata  (ram_rdata)
    );
`else
    assign perr1 = 1'b0;

    avalon_onchip_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .NB     (NB)
    ) u_array (
        .clk    (clk),
        .we     (ram_we),
        .re     (ram_re),
        .idx    (ram_idx),
        .be     (ram_be),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );
`endif

    if (READ_LATENCY >= RL_MAX) begin : g_rl2
        logic              v2_q, v2_d;
        logic              p2_q, p2_d;
        logic [DATA_W-1:0] d2_q, d2_d;

        // Extra output register stage for the longer latency.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v2_q <= 1'b0;
                p2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v2_d;
                p2_q <= p2_d;
                d2_q <= d2_d;
            end
        end

        // Advance the output stage only on enabled cycles.
        always_comb begin
            v2_d = v2_q;
            p2_d = p2_q;
            d2_d = d2_q;
            if (en) begin
                v2_d = v1_q;
                p2_d = perr1;
                d2_d = d1;
            end
        end

        assign out_v = v2_q;
        assign out_p = p2_q;
        assign out_d = d2_q;
    end else begin : g_rl1
        assign out_v = v1_q;
        assign out_p = perr1;
        assign out_d = d1;
    end

    // A pending result is held back while the block is frozen.
    assign bus.readdatavalid = out_v & en;
    assign bus.readdata      = out_v ? out_d : '0;
    assign bus.parity_error  = out_v & en & out_p;
    assign bus.waitrequest   = wreq;

endmodule

// File: tb/tb_avalon_onchip_ram.sv
// Directed bench for avalon_onchip_ram: two instances, latency 1 with clear
// and latency 2 without clear. Parity case runs with AVALON_ONCHIP_RAM_PARITY_EN.
module tb_avalon_onchip_ram;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clken = 1'b1;
    logic reset_req = 1'b0;

    int total = 0;
    int bad = 0;

    avalon_onchip_ram_if #(.DATA_W(32), .ADDR_W(5)) b1 ();
    avalon_onchip_ram_if #(.DATA_W(32), .ADDR_W(5)) b2 ();

    avalon_onchip_ram #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(5),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .reset_req (reset_req),
        .bus       (b1)
    );

    avalon_onchip_ram #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(5),
        .READ_LATENCY(2), .CLEAR_ON_RESET(0)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .reset_req (reset_req),
        .bus       (b2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b1.chipselect = 1'b0; b1.read = 1'b0; b1.write = 1'b0;
        b1.address = '0; b1.byteenable = '0; b1.writedata = '0;
        b2.chipselect = 1'b0; b2.read = 1'b0; b2.write = 1'b0;
        b2.address = '0; b2.byteenable = '0; b2.writedata = '0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        b1.chipselect = 1'b1; b1.write = 1'b1; b1.read = 1'b0;
        b1.address = a; b1.writedata = d; b1.byteenable = be;
        tick();
        idle();
    endtask

    task automatic wr2(input logic [4:0] a, input logic [31:0] d);
        b2.chipselect = 1'b1; b2.write = 1'b1; b2.read = 1'b0;
        b2.address = a; b2.writedata = d; b2.byteenable = 4'hF;
        tick();
        idle();
    endtask

    task automatic rd1_set(input logic [4:0] a);
        b1.chipselect = 1'b1; b1.read = 1'b1; b1.write = 1'b0;
        b1.address = a;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (b1.waitrequest !== 1'b1) begin
            bad++; $display("FAIL reset_wreq1: got %b expected 1", b1.waitrequest);
        end
        total++;
        if (b1.readdatavalid !== 1'b0 || b1.readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd1: got rdv=%b data=%h expected 0/0",
                     b1.readdatavalid, b1.readdata);
        end
        total++;
        if (b1.parity_error !== 1'b0) begin
            bad++; $display("FAIL reset_perr: got %b expected 0", b1.parity_error);
        end
        total++;
        if (b2.waitrequest !== 1'b1 || b2.readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_dut2: got wreq=%b rdv=%b expected 1/0",
                     b2.waitrequest, b2.readdatavalid);
        end
        reset = 1'b0;
    endtask

    task automatic test_clear();
        int n = 0;
        while (b1.waitrequest === 1'b1 && n < 100) begin
            if (n == 0) begin
                total++;
                if (b2.waitrequest !== 1'b1) begin
                    bad++;
                    $display("FAIL noclear_wreq_pre: got %b expected 1", b2.waitrequest);
                end
            end
            if (n == 1) begin
                total++;
                if (b2.waitrequest !== 1'b0) begin
                    bad++;
                    $display("FAIL noclear_wreq_post: got %b expected 0", b2.waitrequest);
                end
            end
            n++;
            tick();
        end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL clear_cycles: got %0d expected 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            rd1_set(5'(i));
            tick();
            total++;
            if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'h0) begin
                bad++;
                $display("FAIL clear_read[%0d]: got rdv=%b data=%h expected 1/0",
                         i, b1.readdatavalid, b1.readdata);
            end
        end
        idle();
        tick();
        total++;
        if (b1.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL clear_rdv_end: got %b expected 0", b1.readdatavalid);
        end
    endtask

    task automatic test_byte_enable();
        wr1(5'd5, 32'hAABBCCDD, 4'hF);
        wr1(5'd5, 32'h11223344, 4'h5);
        rd1_set(5'd5);
        #1;
        total++;
        if (b1.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL be_rdv_early: got %b expected 0", b1.readdatavalid);
        end
        tick();
        idle();
        total++;
        if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'hAA22CC44) begin
            bad++;
            $display("FAIL be_read: got rdv=%b data=%h expected 1/aa22cc44",
                     b1.readdatavalid, b1.readdata);
        end
        total++;
        if (b1.parity_error !== 1'b0) begin
            bad++; $display("FAIL be_perr: got %b expected 0", b1.parity_error);
        end
    endtask

    task automatic test_pipelined();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0000_0101;
        exp_d[1] = 32'h0000_0202;
        exp_d[2] = 32'h0000_0303;
        wr2(5'd1, exp_d[0]);
        wr2(5'd2, exp_d[1]);
        wr2(5'd3, exp_d[2]);
        b2.chipselect = 1'b1; b2.read = 1'b1; b2.address = 5'd1;
        tick();
        total++;
        if (b2.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL pipe_early: got %b expected 0", b2.readdatavalid);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < 2) b2.address = 5'(i + 2);
            else idle();
            tick();
            total++;
            if (b2.readdatavalid !== 1'b1 || b2.readdata !== exp_d[i]) begin
                bad++;
                $display("FAIL pipe_read[%0d]: got rdv=%b data=%h expected 1/%h",
                         i, b2.readdatavalid, b2.readdata, exp_d[i]);
            end
        end
        tick();
        total++;
        if (b2.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL pipe_end: got %b expected 0", b2.readdatavalid);
        end
    endtask

    task automatic test_stall();
        reset_req = 1'b1;
        #1;
        total++;
        if (b1.waitrequest !== 1'b1) begin
            bad++; $display("FAIL resetreq_wreq: got %b expected 1", b1.waitrequest);
        end
        reset_req = 1'b0;
        #1;
        total++;
        if (b1.waitrequest !== 1'b0) begin
            bad++; $display("FAIL resetreq_release: got %b expected 0", b1.waitrequest);
        end
        rd1_set(5'd5);
        tick();
        idle();
        clken = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (b1.readdatavalid !== 1'b0 || b1.waitrequest !== 1'b1) begin
                bad++;
                $display("FAIL stall[%0d]: got rdv=%b wreq=%b expected 0/1",
                         k, b1.readdatavalid, b1.waitrequest);
            end
            tick();
        end
        clken = 1'b1;
        #1;
        total++;
        if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'hAA22CC44) begin
            bad++;
            $display("FAIL stall_resume: got rdv=%b data=%h expected 1/aa22cc44",
                     b1.readdatavalid, b1.readdata);
        end
        tick();
        total++;
        if (b1.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL stall_single: got %b expected 0", b1.readdatavalid);
        end
    endtask

    task automatic test_out_of_range();
        wr1(5'd16, 32'h1, 4'hF);
        rd1_set(5'd16);
        tick();
        total++;
        if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'h0) begin
            bad++;
            $display("FAIL oor_read: got rdv=%b data=%h expected 1/0",
                     b1.readdatavalid, b1.readdata);
        end
        rd1_set(5'd0);
        tick();
        idle();
        total++;
        if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'h0) begin
            bad++;
            $display("FAIL oor_alias: got rdv=%b data=%h expected 1/0",
                     b1.readdatavalid, b1.readdata);
        end
    endtask

    task automatic test_conflict();
        b1.chipselect = 1'b1; b1.read = 1'b1; b1.write = 1'b1;
        b1.address = 5'd7; b1.writedata = 32'h77665544; b1.byteenable = 4'hF;
        tick();
        idle();
        total++;
        if (b1.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL conflict_rdv: got %b expected 0", b1.readdatavalid);
        end
        rd1_set(5'd7);
        tick();
        idle();
        total++;
        if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'h77665544) begin
            bad++;
            $display("FAIL conflict_write: got rdv=%b data=%h expected 1/77665544",
                     b1.readdatavalid, b1.readdata);
        end
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        rd1_set(5'd5);
        tick();
        idle();
        total++;
        if (b1.readdatavalid !== 1'b1) begin
            bad++; $display("FAIL midrst_pre: got %b expected 1", b1.readdatavalid);
        end
        reset = 1'b1;
        #1;
        total++;
        if (b1.readdatavalid !== 1'b0 || b1.readdata !== 32'h0 ||
            b1.waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL midrst_outs: got rdv=%b data=%h wreq=%b expected 0/0/1",
                     b1.readdatavalid, b1.readdata, b1.waitrequest);
        end
        tick();
        reset = 1'b0;
        while (b1.waitrequest === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL midrst_clear: got %0d expected 16", n);
        end
        rd1_set(5'd5);
        tick();
        idle();
        total++;
        if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'h0) begin
            bad++;
            $display("FAIL midrst_zeroed: got rdv=%b data=%h expected 1/0",
                     b1.readdatavalid, b1.readdata);
        end
    endtask

`ifdef AVALON_ONCHIP_RAM_PARITY_EN
    task automatic test_parity();
        dut1.u_array.mem[3] = dut1.u_array.mem[3] ^ 32'h0000_0001;
        rd1_set(5'd3);
        tick();
        idle();
        total++;
        if (b1.readdatavalid !== 1'b1 || b1.parity_error !== 1'b1) begin
            bad++;
            $display("FAIL parity_flag: got rdv=%b perr=%b expected 1/1",
                     b1.readdatavalid, b1.parity_error);
        end
        tick();
        total++;
        if (b1.parity_error !== 1'b0) begin
            bad++; $display("FAIL parity_pulse: got %b expected 0", b1.parity_error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clear();
        test_byte_enable();
        test_pipelined();
        test_stall();
        test_out_of_range();
        test_conflict();
        test_reset_mid_read();
`ifdef AVALON_ONCHIP_RAM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
